// File: rtl/exec_ctrl_collector_pkg.sv
// Shared completion-path configuration and the ctrlPkt completion packet.
package exec_ctrl_collector_pkg;

  localparam int CFG_ISSUE_WIDTH       = 4;
  localparam int COMPLETION_WR_PORTS   = 2;
  localparam int COMPLETION_FIFO_DEPTH = 16;

  // Completion packet emitted by each pipe's writeback stage.
  typedef struct packed {
    logic       valid;
    logic [7:0] seqNo;
    logic [5:0] alId;
    logic       mispredict;
  } ctrlPkt;

endpackage

// File: rtl/exec_ctrl_collector_compact.sv
// Prefix-count compactor: dense slot offset for every lane plus the total
// number of valid lanes. Offsets of invalid lanes are don't-care.
module exec_ctrl_compact #(
  parameter int LANES = 4,
  parameter int OW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]         i_valid,
  output logic [LANES-1:0][OW-1:0] o_offset,
  output logic [OW-1:0]            o_count
);

  logic [LANES:0][OW-1:0] w_prefix;

  assign w_prefix[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_prefix[gi+1] = w_prefix[gi] + OW'(i_valid[gi]);
      assign o_offset[gi]   = w_prefix[gi];
    end
  endgenerate

  assign o_count = w_prefix[LANES];

endmodule

// File: rtl/exec_ctrl_collector.sv
// Completion collector: compacts per-pipe ctrlPkt completions into an
// age-ordered FIFO and drains up to WR_PORTS per cycle into the active list.
module exec_ctrl_collector
  import exec_ctrl_collector_pkg::*;
#(
  parameter int ISSUE_WIDTH  = CFG_ISSUE_WIDTH,
  parameter int WR_PORTS     = COMPLETION_WR_PORTS,
  parameter int DEPTH        = COMPLETION_FIFO_DEPTH,
  parameter int STALL_THRESH = 3 * ISSUE_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   recoverFlag_i,
  input  logic                   exceptionFlag_i,
  input  ctrlPkt                 ctrlPacket_i [ISSUE_WIDTH],
  input  logic                   alWrEnable_i,
  output ctrlPkt                 ctrlPacket_o [WR_PORTS],
  output logic                   stallIssue_o,
  output logic [$clog2(DEPTH):0] occupancy_o,
  output logic                   overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(ISSUE_WIDTH + 1);

  ctrlPkt        r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic                            w_flush;
  logic [ISSUE_WIDTH-1:0]          w_in_valid;
  logic [ISSUE_WIDTH-1:0][OW-1:0]  w_offset;
  logic [OW-1:0]                   w_n_enq;
  logic [CW-1:0]                   w_space;
  logic                            w_drop;
  logic [CW-1:0]                   w_n_acc;
  logic [CW-1:0]                   w_n_deq;
  logic [ISSUE_WIDTH-1:0]          w_wr_en;
  logic [ISSUE_WIDTH-1:0][PW-1:0]  w_wr_idx;

  assign w_flush = recoverFlag_i | exceptionFlag_i;

  // Space is judged on pre-edge state only; same-cycle dequeues do not help.
  assign w_space = CW'(DEPTH) - r_count;

  exec_ctrl_compact #(
    .LANES (ISSUE_WIDTH),
    .OW    (OW)
  ) u_compact (
    .i_valid  (w_in_valid),
    .o_offset (w_offset),
    .o_count  (w_n_enq)
  );

  // A lane is written only if its compacted offset still fits; higher
  // pipe indices are the ones dropped when the FIFO runs out of room.
  genvar gi;
  generate
    for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_in
      assign w_in_valid[gi] = ctrlPacket_i[gi].valid;
      assign w_wr_en[gi]    = w_in_valid[gi] & ~w_flush & (CW'(w_offset[gi]) < w_space);
      assign w_wr_idx[gi]   = r_tail + PW'(w_offset[gi]);
    end
  endgenerate

  assign w_drop  = ~w_flush & (CW'(w_n_enq) > w_space);
  assign w_n_acc = w_drop ? w_space : CW'(w_n_enq);

  // Dequeue count: oldest min(count, WR_PORTS) entries when the active list accepts.
  always_comb begin
    w_n_deq = '0;
    if (alWrEnable_i) begin
      if (r_count < CW'(WR_PORTS)) begin
        w_n_deq = r_count;
      end else begin
        w_n_deq = CW'(WR_PORTS);
      end
    end
  end

  // Pointer, count and sticky overflow state; reset outranks flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_n_deq);
      r_tail  <= r_tail + PW'(w_n_acc);
      r_count <= r_count + w_n_acc - w_n_deq;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Entry payload storage; unoccupied slots are never reported as valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (w_wr_en[i]) begin
        r_mem[w_wr_idx[i]] <= ctrlPacket_i[i];
      end
    end
  end

  // Oldest-first read window; valid reflects occupancy, not the stored bit.
  always_comb begin
    for (int i = 0; i < WR_PORTS; i++) begin
      ctrlPacket_o[i]       = r_mem[r_head + PW'(i)];
      ctrlPacket_o[i].valid = (CW'(i) < r_count);
    end
  end

  assign stallIssue_o = (w_space < CW'(STALL_THRESH));
  assign occupancy_o  = r_count;
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_exec_ctrl_collector.sv
// Directed bench for exec_ctrl_collector (ISSUE_WIDTH=4, WR_PORTS=2, DEPTH=16).
module tb_exec_ctrl_collector;
  import exec_ctrl_collector_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       recover;
  logic       exception;
  logic       wr_en;
  ctrlPkt     pkt_in  [4];
  ctrlPkt     pkt_out [2];
  logic       stall;
  logic [4:0] occ;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  exec_ctrl_collector dut (
    .clk             (clk),
    .reset           (reset),
    .recoverFlag_i   (recover),
    .exceptionFlag_i (exception),
    .ctrlPacket_i    (pkt_in),
    .alWrEnable_i    (wr_en),
    .ctrlPacket_o    (pkt_out),
    .stallIssue_o    (stall),
    .occupancy_o     (occ),
    .overflow_o      (ovf)
  );

  always #5 clk = ~clk;

  function automatic ctrlPkt mk(input logic [7:0] seq);
    ctrlPkt p;
    p.valid      = 1'b1;
    p.seqNo      = seq;
    p.alId       = seq[5:0];
    p.mispredict = seq[0];
    return p;
  endfunction

  task automatic drive(input logic [3:0] mask, input logic [7:0] base);
    for (int j = 0; j < 4; j++) begin
      pkt_in[j] = mask[j] ? mk(8'(base + j)) : '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; recover = 1'b0; exception = 1'b0; wr_en = 1'b0;
    drive(4'h0, 8'h0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_occ", occ, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_v0", pkt_out[0].valid, 0);
    chk("rst_v1", pkt_out[1].valid, 0);

    // 1: single packet on pipe 2, one-cycle latency, then drained
    drive(4'b0100, 8'hA3);
    wr_en = 1'b1;
    tick();
    drive(4'h0, 8'h0);
    chk("t1_pkt0", pkt_out[0], mk(8'hA5));
    chk("t1_v1", pkt_out[1].valid, 0);
    chk("t1_occ", occ, 1);
    tick();
    chk("t1_occ_drained", occ, 0);
    chk("t1_v0_drained", pkt_out[0].valid, 0);

    // 2: fill with four full bursts, then overflow on a fifth
    wr_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(4'hF, 8'(4 * k));
      tick();
      chk("t2_occ", occ, 32'(4 * (k + 1)));
      chk("t2_stall", stall, (k >= 1) ? 1 : 0);
    end
    chk("t2_out0", pkt_out[0].seqNo, 0);
    chk("t2_out1", pkt_out[1].seqNo, 1);
    chk("t2_ovf_pre", ovf, 0);
    drive(4'hF, 8'd16);
    tick();
    drive(4'h0, 8'h0);
    chk("t2_occ_full", occ, 16);
    chk("t2_ovf", ovf, 1);
    chk("t2_out0_kept", pkt_out[0].seqNo, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t2_rst_occ", occ, 0);
    chk("t2_rst_ovf", ovf, 0);

    // 3: 14 entries, drain 12 (head=12, tail=14), then a wrapping enqueue
    drive(4'hF, 8'd0);  tick();
    drive(4'hF, 8'd4);  tick();
    drive(4'hF, 8'd8);  tick();
    drive(4'h3, 8'd12); tick();
    drive(4'h0, 8'h0);
    chk("t3_occ14", occ, 14);
    chk("t3_stall14", stall, 1);
    wr_en = 1'b1;
    repeat (6) tick();
    chk("t3_occ2", occ, 2);
    chk("t3_out0_a", pkt_out[0].seqNo, 12);
    chk("t3_out1_a", pkt_out[1].seqNo, 13);
    wr_en = 1'b0;
    drive(4'hF, 8'd14);
    tick();
    drive(4'h0, 8'h0);
    chk("t3_occ6", occ, 6);
    wr_en = 1'b1;
    chk("t3_out0_b", pkt_out[0].seqNo, 12);
    chk("t3_out1_b", pkt_out[1].seqNo, 13);
    tick();
    chk("t3_out0_c", pkt_out[0].seqNo, 14);
    chk("t3_out1_c", pkt_out[1].seqNo, 15);
    tick();
    chk("t3_out0_d", pkt_out[0].seqNo, 16);
    chk("t3_out1_d", pkt_out[1].seqNo, 17);
    chk("t3_occ_d", occ, 2);
    tick();
    chk("t3_occ_e", occ, 0);
    chk("t3_v0_e", pkt_out[0].valid, 0);

    // 4: simultaneous enqueue/dequeue, then full FIFO with dequeue
    wr_en = 1'b0;
    drive(4'h7, 8'd20);
    tick();
    chk("t4_occ3", occ, 3);
    drive(4'hF, 8'd30);
    wr_en = 1'b1;
    chk("t4_out0_a", pkt_out[0].seqNo, 20);
    chk("t4_out1_a", pkt_out[1].seqNo, 21);
    tick();
    chk("t4_occ5", occ, 5);
    chk("t4_out0_b", pkt_out[0].seqNo, 22);
    chk("t4_out1_b", pkt_out[1].seqNo, 30);
    wr_en = 1'b0;
    drive(4'hF, 8'd40); tick();
    drive(4'hF, 8'd44); tick();
    drive(4'h7, 8'd48); tick();
    chk("t4_occ16", occ, 16);
    chk("t4_ovf_pre", ovf, 0);
    drive(4'hF, 8'd60);
    wr_en = 1'b1;
    tick();
    drive(4'h0, 8'h0);
    wr_en = 1'b0;
    chk("t4_occ14", occ, 14);
    chk("t4_ovf", ovf, 1);
    chk("t4_out0_c", pkt_out[0].seqNo, 31);
    chk("t4_out1_c", pkt_out[1].seqNo, 32);

    // 5: flush via recover, then via exception
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int f = 0; f < 2; f++) begin
      drive(4'hF, 8'd0); tick();
      drive(4'hF, 8'd4); tick();
      drive(4'h1, 8'd8); tick();
      chk("t5_occ9", occ, 9);
      drive(4'h7, 8'd70);
      recover   = (f == 0);
      exception = (f == 1);
      tick();
      recover   = 1'b0;
      exception = 1'b0;
      drive(4'h0, 8'h0);
      chk("t5_occ0", occ, 0);
      chk("t5_v0", pkt_out[0].valid, 0);
      chk("t5_v1", pkt_out[1].valid, 0);
      chk("t5_stall", stall, 0);
      chk("t5_ovf", ovf, 0);
    end
    drive(4'h1, 8'd99);
    tick();
    drive(4'h0, 8'h0);
    chk("t5_post_seq", pkt_out[0].seqNo, 99);
    chk("t5_post_occ", occ, 1);

    // 6: reset mid-stream with count=7 and overflow set
    drive(4'hF, 8'd100); tick();
    drive(4'hF, 8'd104); tick();
    drive(4'hF, 8'd108); tick();
    drive(4'hF, 8'd112); tick();
    drive(4'h0, 8'h0);
    chk("t6_occ16", occ, 16);
    chk("t6_ovf", ovf, 1);
    wr_en = 1'b1;
    repeat (5) tick();
    wr_en = 1'b0;
    drive(4'h1, 8'd120);
    tick();
    chk("t6_occ7", occ, 7);
    chk("t6_ovf7", ovf, 1);
    drive(4'hF, 8'd130);
    wr_en = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr_en = 1'b0;
    drive(4'h0, 8'h0);
    chk("t6_occ0", occ, 0);
    chk("t6_ovf0", ovf, 0);
    chk("t6_stall0", stall, 0);
    chk("t6_v0", pkt_out[0].valid, 0);
    chk("t6_v1", pkt_out[1].valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
